// File: rtl/column_frame_renderer_pkg.sv
// Shared types and defaults for the column renderer: FSM states, the
// per-pixel colour source, and the row-to-colour decision.
package column_frame_renderer_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DRAW = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_CEIL  = 2'd0,
    SEL_WALL  = 2'd1,
    SEL_FLOOR = 2'd2
  } color_sel_t;

  // Rows above the wall span are ceiling and rows at or below bot are floor.
  function automatic color_sel_t pick_sel(input int y, input int top, input int bot);
    color_sel_t sel;
    if (y < top) begin
      sel = SEL_CEIL;
    end else if (y < bot) begin
      sel = SEL_WALL;
    end else begin
      sel = SEL_FLOOR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/column_frame_renderer_if.sv
// Slice-request handshake towards the raycaster and pixel write port
// towards the frame buffer. The renderer is the master of both.
interface column_frame_renderer_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic               slice_req;
  logic [X_W-1:0]     slice_column;
  logic               slice_valid;
  logic [Y_W-1:0]     slice_size;
  logic [COLOR_W-1:0] slice_color;

  logic               plot_en;
  logic               plot_ready;
  logic [X_W-1:0]     plot_x;
  logic [Y_W-1:0]     plot_y;
  logic [COLOR_W-1:0] plot_color;

  modport master (
    output slice_req, slice_column,
    input  slice_valid, slice_size, slice_color,
    output plot_en, plot_x, plot_y, plot_color,
    input  plot_ready
  );

  modport slave (
    input  slice_req, slice_column,
    output slice_valid, slice_size, slice_color,
    input  plot_en, plot_x, plot_y, plot_color,
    output plot_ready
  );
endinterface

// File: rtl/column_frame_renderer_slice_span_calc.sv
// Clamps a wall height to the screen and centres it vertically,
// giving the first wall row and the exclusive end row.
module slice_span_calc
  import column_frame_renderer_pkg::*;
#(
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int Y_W      = 7
) (
  input  logic [Y_W-1:0] slice_size,
  output logic [Y_W-1:0] size_c,
  output logic [Y_W-1:0] top,
  output logic [Y_W-1:0] bot
);

  localparam logic [Y_W:0] H_EXT = (Y_W + 1)'(SCREEN_H);

  logic [Y_W:0] w_size_ext;
  logic [Y_W:0] w_size_c;
  logic [Y_W:0] w_gap;

  // One extra bit keeps the gap subtraction from wrapping.
  always_comb begin
    w_size_ext = {1'b0, slice_size};
    w_size_c   = (w_size_ext > H_EXT) ? H_EXT : w_size_ext;
    w_gap      = H_EXT - w_size_c;
  end

  assign size_c = w_size_c[Y_W-1:0];
  assign top    = w_gap[Y_W:1];
  assign bot    = w_gap[Y_W:1] + w_size_c[Y_W-1:0];

endmodule

// File: rtl/column_frame_renderer.sv
// Per-frame column renderer: fetches one wall slice per column, then writes
// that column top to bottom (ceiling, wall, floor) into the frame buffer.
module column_frame_renderer
  import column_frame_renderer_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int FILL_BG  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [COLOR_W-1:0]  ceil_color,
  input  logic [COLOR_W-1:0]  floor_color,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_overrun,
  column_frame_renderer_if.master bus
);

  localparam logic [X_W-1:0] LAST_COL = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] LAST_ROW = Y_W'(SCREEN_H - 1);
  localparam bit             FILL     = (FILL_BG != 0);

  state_t             r_state, w_state_next;
  logic               r_tick_q;
  logic [X_W-1:0]     r_column, w_column_next;
  logic [COLOR_W-1:0] r_ceil, w_ceil_next;
  logic [COLOR_W-1:0] r_floor, w_floor_next;
  logic [COLOR_W-1:0] r_wall, w_wall_next;
  logic [Y_W-1:0]     r_top, w_top_next;
  logic [Y_W-1:0]     r_bot, w_bot_next;
  logic               r_plot_en, w_plot_en_next;
  logic [X_W-1:0]     r_plot_x, w_plot_x_next;
  logic [Y_W-1:0]     r_plot_y, w_plot_y_next;
  logic [COLOR_W-1:0] r_plot_color, w_plot_color_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               r_overrun, w_overrun_next;

  logic [Y_W-1:0]     w_size_c, w_top, w_bot;
  logic [Y_W-1:0]     w_first_y, w_last_y, w_y_inc;
  logic               w_edge, w_col_end;

  slice_span_calc #(
    .SCREEN_H (SCREEN_H),
    .Y_W      (Y_W)
  ) u_span (
    .slice_size (bus.slice_size),
    .size_c     (w_size_c),
    .top        (w_top),
    .bot        (w_bot)
  );

  function automatic logic [COLOR_W-1:0] sel_color(
    input color_sel_t         sel,
    input logic [COLOR_W-1:0] ceil_c,
    input logic [COLOR_W-1:0] wall_c,
    input logic [COLOR_W-1:0] floor_c
  );
    logic [COLOR_W-1:0] c;
    case (sel)
      SEL_CEIL: c = ceil_c;
      SEL_WALL: c = wall_c;
      default:  c = floor_c;
    endcase
    return c;
  endfunction

  always_comb begin
    w_edge            = frame_tick & ~r_tick_q;
    w_first_y         = FILL ? '0 : w_top;
    w_last_y          = FILL ? LAST_ROW : (r_bot - Y_W'(1));
    w_y_inc           = r_plot_y + Y_W'(1);
    w_state_next      = r_state;
    w_column_next     = r_column;
    w_ceil_next       = r_ceil;
    w_floor_next      = r_floor;
    w_wall_next       = r_wall;
    w_top_next        = r_top;
    w_bot_next        = r_bot;
    w_plot_en_next    = r_plot_en;
    w_plot_x_next     = r_plot_x;
    w_plot_y_next     = r_plot_y;
    w_plot_color_next = r_plot_color;
    w_busy_next       = r_busy;
    w_done_next       = 1'b0;
    w_overrun_next    = w_edge && (r_state != ST_IDLE);
    w_col_end         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_ceil_next   = ceil_color;
          w_floor_next  = floor_color;
          w_column_next = '0;
          w_busy_next   = 1'b1;
          w_state_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.slice_valid) begin
          w_wall_next = bus.slice_color;
          w_top_next  = w_top;
          w_bot_next  = w_bot;
          if (!FILL && (w_size_c == '0)) begin
            w_col_end = 1'b1;
          end else begin
            // First pixel goes out straight from the live slice so the column
            // streams without a bubble after the handshake.
            w_state_next      = ST_DRAW;
            w_plot_en_next    = 1'b1;
            w_plot_x_next     = r_column;
            w_plot_y_next     = w_first_y;
            w_plot_color_next = sel_color(pick_sel(int'(w_first_y), int'(w_top), int'(w_bot)),
                                          r_ceil, bus.slice_color, r_floor);
          end
        end
      end
      ST_DRAW: begin
        if (bus.plot_ready) begin
          if (r_plot_y == w_last_y) begin
            w_plot_en_next = 1'b0;
            w_col_end      = 1'b1;
          end else begin
            w_plot_y_next     = w_y_inc;
            w_plot_color_next = sel_color(pick_sel(int'(w_y_inc), int'(r_top), int'(r_bot)),
                                          r_ceil, r_wall, r_floor);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_col_end) begin
      if (r_column == LAST_COL) begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b1;
      end else begin
        w_column_next = r_column + X_W'(1);
        w_state_next  = ST_REQ;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tick_q     <= 1'b0;
      r_column     <= '0;
      r_ceil       <= '0;
      r_floor      <= '0;
      r_wall       <= '0;
      r_top        <= '0;
      r_bot        <= '0;
      r_plot_en    <= 1'b0;
      r_plot_x     <= '0;
      r_plot_y     <= '0;
      r_plot_color <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tick_q     <= frame_tick;
      r_column     <= w_column_next;
      r_ceil       <= w_ceil_next;
      r_floor      <= w_floor_next;
      r_wall       <= w_wall_next;
      r_top        <= w_top_next;
      r_bot        <= w_bot_next;
      r_plot_en    <= w_plot_en_next;
      r_plot_x     <= w_plot_x_next;
      r_plot_y     <= w_plot_y_next;
      r_plot_color <= w_plot_color_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_overrun    <= w_overrun_next;
    end
  end

  assign bus.slice_req    = (r_state == ST_REQ);
  assign bus.slice_column = r_column;
  assign bus.plot_en      = r_plot_en;
  assign bus.plot_x       = r_plot_x;
  assign bus.plot_y       = r_plot_y;
  assign bus.plot_color   = r_plot_color;
  assign busy             = r_busy;
  assign frame_done       = r_done;
  assign frame_overrun    = r_overrun;

endmodule

// File: tb/tb_column_frame_renderer.sv
// Directed bench: full-size frames with a scripted raycaster and frame buffer,
// a reduced wall-only instance, and the span calculator on its own.
module tb_column_frame_renderer;

  logic clk;
  logic rst_a, rst_b;
  logic tick_a, tick_b;
  logic [2:0] ceil_a, floor_a, ceil_b, floor_b;
  logic busy_a, done_a, ovr_a;
  logic busy_b, done_b, ovr_b;

  int n_vec = 0;
  int n_bad = 0;

  column_frame_renderer_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) bus_a ();
  column_frame_renderer_if #(.X_W(2), .Y_W(4), .COLOR_W(3)) bus_b ();

  column_frame_renderer u_dut (
    .clock(clk), .reset(rst_a), .frame_tick(tick_a),
    .ceil_color(ceil_a), .floor_color(floor_a),
    .busy(busy_a), .frame_done(done_a), .frame_overrun(ovr_a),
    .bus(bus_a)
  );

  column_frame_renderer #(
    .SCREEN_W(4), .SCREEN_H(8), .X_W(2), .Y_W(4), .COLOR_W(3), .FILL_BG(0)
  ) u_small (
    .clock(clk), .reset(rst_b), .frame_tick(tick_b),
    .ceil_color(ceil_b), .floor_color(floor_b),
    .busy(busy_b), .frame_done(done_b), .frame_overrun(ovr_b),
    .bus(bus_b)
  );

  logic [6:0] span_size, span_sc, span_top, span_bot;
  slice_span_calc #(.SCREEN_H(120), .Y_W(7)) u_span (
    .slice_size(span_size), .size_c(span_sc), .top(span_top), .bot(span_bot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Frame B column pattern (col % 4). 127 is the largest 7-bit size and
  // stands in for an over-range height.
  localparam int SIZES [4] = '{40, 127, 0, 41};
  localparam int TOPS  [4] = '{40,   0, 60, 39};
  localparam int BOTS  [4] = '{80, 120, 60, 80};

  bit mode_b = 1'b0;
  bit small_mode = 1'b0;

  function automatic logic [2:0] wall_of(input int col);
    if (!mode_b) return 3'd5;
    return (col % 2 == 1) ? 3'd7 : 3'd5;
  endfunction

  function automatic logic [2:0] exp_color(input int col, input int y);
    int t, b;
    if (mode_b) begin
      t = TOPS[col % 4];
      b = BOTS[col % 4];
    end else begin
      t = 40;
      b = 80;
    end
    if (y < t) return mode_b ? 3'd3 : 3'd1;
    if (y < b) return wall_of(col);
    return mode_b ? 3'd6 : 3'd2;
  endfunction

  // Full-size raycaster, frame buffer and pixel scoreboard.
  logic [2:0] fb [160][120];
  int acc_a, pix_err, stab_err, done_cnt_a, ov_cnt_a, stall_cnt;
  int exp_col, exp_y, wait_n, held_cnt, held_plot;
  bit prev_stall;
  logic [7:0] px;
  logic [6:0] py;
  logic [2:0] pc;

  always @(negedge clk) begin
    int col;
    col = int'(bus_a.slice_column);
    if (bus_a.slice_req) begin
      if (mode_b && col == 7 && wait_n < 5) begin
        bus_a.slice_valid = 1'b0;
        wait_n++;
      end else begin
        bus_a.slice_valid = 1'b1;
        bus_a.slice_size  = mode_b ? 7'(SIZES[col % 4]) : 7'd40;
        bus_a.slice_color = wall_of(col);
      end
    end else begin
      bus_a.slice_valid = 1'b0;
    end
    if (mode_b && bus_a.slice_req && col == 7 && !bus_a.slice_valid) begin
      held_cnt++;
      if (bus_a.plot_en) held_plot++;
    end

    bus_a.plot_ready = mode_b ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (prev_stall && (!bus_a.plot_en || bus_a.plot_x != px ||
                       bus_a.plot_y != py || bus_a.plot_color != pc))
      stab_err++;
    prev_stall = bus_a.plot_en && !bus_a.plot_ready;
    if (prev_stall) stall_cnt++;
    px = bus_a.plot_x;
    py = bus_a.plot_y;
    pc = bus_a.plot_color;

    if (bus_a.plot_en && bus_a.plot_ready) begin
      acc_a++;
      if (int'(bus_a.plot_x) != exp_col || int'(bus_a.plot_y) != exp_y ||
          bus_a.plot_color != exp_color(exp_col, exp_y))
        pix_err++;
      if (bus_a.plot_x < 8'd160 && bus_a.plot_y < 7'd120)
        fb[bus_a.plot_x][bus_a.plot_y] = bus_a.plot_color;
      exp_y++;
      if (exp_y == 120) begin
        exp_y = 0;
        exp_col++;
      end
    end
    if (done_a) done_cnt_a++;
    if (ovr_a) ov_cnt_a++;
  end

  // Reduced wall-only instance: always-valid raycaster, always-ready sink.
  typedef struct packed {
    logic [1:0] x;
    logic [3:0] y;
    logic [2:0] c;
  } pix_t;
  pix_t q_b[$];
  int done_cnt_b;

  always @(negedge clk) begin
    pix_t p;
    bus_b.slice_valid = bus_b.slice_req;
    bus_b.slice_size  = (small_mode && bus_b.slice_column == 2'd2) ? 4'd0 : 4'd2;
    bus_b.slice_color = 3'd2;
    bus_b.plot_ready  = 1'b1;
    if (bus_b.plot_en) begin
      p.x = bus_b.plot_x;
      p.y = bus_b.plot_y;
      p.c = bus_b.plot_color;
      q_b.push_back(p);
    end
    if (done_b) done_cnt_b++;
  end

  task automatic clear_a();
    acc_a = 0; pix_err = 0; stab_err = 0; done_cnt_a = 0; ov_cnt_a = 0;
    stall_cnt = 0; exp_col = 0; exp_y = 0; wait_n = 0; held_cnt = 0;
    held_plot = 0; prev_stall = 1'b0;
  endtask

  localparam int SPAN_IN  [7] = '{40, 127,  0, 41, 120, 121,  1};
  localparam int SPAN_TOP [7] = '{40,   0, 60, 39,   0,   0, 59};
  localparam int SPAN_BOT [7] = '{80, 120, 60, 80, 120, 120, 60};
  localparam int SPAN_SC  [7] = '{40, 120,  0, 41, 120, 120,  1};

  initial begin
    int cnt;
    bit got_done;
    rst_a = 1'b1; rst_b = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
    ceil_a = '0; floor_a = '0; ceil_b = 3'd1; floor_b = 3'd4;
    bus_a.slice_valid = 1'b0; bus_a.slice_size = '0; bus_a.slice_color = '0; bus_a.plot_ready = 1'b0;
    bus_b.slice_valid = 1'b0; bus_b.slice_size = '0; bus_b.slice_color = '0; bus_b.plot_ready = 1'b0;
    span_size = '0;
    clear_a();
    done_cnt_b = 0;

    // span calculator on its own
    for (int i = 0; i < 7; i++) begin
      span_size = 7'(SPAN_IN[i]);
      #1;
      check_val($sformatf("span_top_%0d", SPAN_IN[i]), span_top, SPAN_TOP[i]);
      check_val($sformatf("span_bot_%0d", SPAN_IN[i]), span_bot, SPAN_BOT[i]);
      check_val($sformatf("span_sc_%0d", SPAN_IN[i]), span_sc, SPAN_SC[i]);
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy_a, 0);
    check_val("rst_done", done_a, 0);
    check_val("rst_overrun", ovr_a, 0);
    check_val("rst_slice_req", bus_a.slice_req, 0);
    check_val("rst_slice_col", bus_a.slice_column, 0);
    check_val("rst_plot_en", bus_a.plot_en, 0);
    check_val("rst_plot_xyc", {bus_a.plot_x, bus_a.plot_y, bus_a.plot_color}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Frame A: size 40, valid/ready always high, colours changed after start
    @(posedge clk);
    #1;
    clear_a();
    mode_b = 1'b0;
    ceil_a = 3'd1;
    floor_a = 3'd2;
    tick_a = 1'b1;
    cnt = 0;
    got_done = 1'b0;
    while (!got_done && cnt < 25000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 3) tick_a = 1'b0;
      if (cnt == 10) begin
        ceil_a = 3'd0;
        floor_a = 3'd0;
      end
      if (done_a) got_done = 1'b1;
    end
    check_val("A_latency", cnt, 19361);
    repeat (3) @(posedge clk);
    #1;
    check_val("A_pixels", acc_a, 19200);
    check_val("A_pix_err", pix_err, 0);
    check_val("A_done_pulses", done_cnt_a, 1);
    check_val("A_overrun", ov_cnt_a, 0);
    check_val("A_busy_end", busy_a, 0);
    check_val("A_c0_y39", fb[0][39], 1);
    check_val("A_c0_y40", fb[0][40], 5);
    check_val("A_c159_y79", fb[159][79], 5);
    check_val("A_c159_y80", fb[159][80], 2);

    // Frame B: mixed sizes, random ready, late slice on column 7, extra tick
    @(posedge clk);
    #1;
    clear_a();
    mode_b = 1'b1;
    ceil_a = 3'd3;
    floor_a = 3'd6;
    tick_a = 1'b1;
    cnt = 0;
    got_done = 1'b0;
    while (!got_done && cnt < 45000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 2) tick_a = 1'b0;
      if (cnt == 10) begin
        ceil_a = 3'd0;
        floor_a = 3'd0;
      end
      if (cnt == 5000) tick_a = 1'b1;
      if (cnt == 5001) tick_a = 1'b0;
      if (done_a) got_done = 1'b1;
    end
    check_val("B_done_seen", got_done, 1);
    repeat (3) @(posedge clk);
    #1;
    check_val("B_pixels", acc_a, 19200);
    check_val("B_pix_err", pix_err, 0);
    check_val("B_stable_err", stab_err, 0);
    check_val("B_stalls_seen", stall_cnt > 0, 1);
    check_val("B_done_pulses", done_cnt_a, 1);
    check_val("B_overrun", ov_cnt_a, 1);
    check_val("B_c7_held", held_cnt, 5);
    check_val("B_c7_plot", held_plot, 0);
    check_val("B_c0_y39", fb[0][39], 3);
    check_val("B_c0_y40", fb[0][40], 5);
    check_val("B_c1_y0", fb[1][0], 7);
    check_val("B_c1_y119", fb[1][119], 7);
    check_val("B_c2_y59", fb[2][59], 3);
    check_val("B_c2_y60", fb[2][60], 6);
    check_val("B_c3_y38", fb[3][38], 3);
    check_val("B_c3_y39", fb[3][39], 7);
    check_val("B_c3_y79", fb[3][79], 7);
    check_val("B_c3_y80", fb[3][80], 6);
    check_val("B_c159_y39", fb[159][39], 7);

    // Small frame 1: size 2 everywhere, rows 3 and 4 only
    @(posedge clk);
    #1;
    q_b.delete();
    done_cnt_b = 0;
    small_mode = 1'b0;
    tick_b = 1'b1;
    cnt = 0;
    got_done = 1'b0;
    while (!got_done && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      tick_b = 1'b0;
      if (done_b) got_done = 1'b1;
    end
    check_val("S1_latency", cnt, 13);
    repeat (2) @(posedge clk);
    #1;
    check_val("S1_count", q_b.size(), 8);
    check_val("S1_done_pulses", done_cnt_b, 1);
    for (int i = 0; i < q_b.size(); i++) begin
      check_val($sformatf("S1_x%0d", i), q_b[i].x, i / 2);
      check_val($sformatf("S1_y%0d", i), q_b[i].y, 3 + (i % 2));
      check_val($sformatf("S1_c%0d", i), q_b[i].c, 2);
    end

    // Small frame 2: column 2 has an empty slice and emits nothing
    @(posedge clk);
    #1;
    q_b.delete();
    done_cnt_b = 0;
    small_mode = 1'b1;
    tick_b = 1'b1;
    cnt = 0;
    got_done = 1'b0;
    while (!got_done && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      tick_b = 1'b0;
      if (done_b) got_done = 1'b1;
    end
    check_val("S2_latency", cnt, 11);
    repeat (2) @(posedge clk);
    #1;
    check_val("S2_count", q_b.size(), 6);
    for (int i = 0; i < q_b.size(); i++) begin
      check_val($sformatf("S2_x%0d", i), q_b[i].x, (i < 4) ? (i / 2) : 3);
      check_val($sformatf("S2_y%0d", i), q_b[i].y, 3 + (i % 2));
    end

    // Small frame 3: reset while column 1 is being drawn
    @(posedge clk);
    #1;
    done_cnt_b = 0;
    small_mode = 1'b0;
    tick_b = 1'b1;
    cnt = 0;
    got_done = 1'b0;
    while (!got_done && cnt < 50) begin
      @(posedge clk);
      cnt++;
      #1;
      tick_b = 1'b0;
      if (bus_b.plot_en && bus_b.plot_x == 2'd1) got_done = 1'b1;
    end
    check_val("S3_reached_col1", got_done, 1);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check_val("S3_rst_busy", busy_b, 0);
    check_val("S3_rst_req", bus_b.slice_req, 0);
    check_val("S3_rst_col", bus_b.slice_column, 0);
    check_val("S3_rst_plot_en", bus_b.plot_en, 0);
    check_val("S3_rst_plot_xyc", {bus_b.plot_x, bus_b.plot_y, bus_b.plot_color}, 0);
    check_val("S3_rst_done", done_b, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_val("S3_no_done", done_cnt_b, 0);
    check_val("S3_idle_busy", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
